// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down modulus counter family.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // Out-of-range load values clamp to the top of the count range.
  function automatic int unsigned clamp_load(input int unsigned value,
                                             input int unsigned max_val);
    return (value > max_val) ? max_val : value;
  endfunction

endpackage

// File: rtl/count_next.sv
// Next-state, terminal-count and wrap-event logic for updown_mod_counter (purely combinational).
module count_next
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
  parameter int unsigned SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_dn,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_count,
  output logic             tc,
  output logic             wrap_event
);

  localparam logic [WIDTH:0]   MaxExt = (WIDTH + 1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MaxCnt = WIDTH'(MAX_VAL);

  logic [WIDTH:0] step_up;
  logic [WIDTH:0] step_dn;
  logic           up_ovf;
  logic           dn_unf;
  logic           at_bound;
  logic           dir_up;

  // One extra bit exposes the carry/borrow so the modulus test needs no separate compare on count.
  assign step_up  = {1'b0, count} + (WIDTH + 1)'(1);
  assign step_dn  = {1'b0, count} - (WIDTH + 1)'(1);
  assign up_ovf   = (step_up > MaxExt);
  assign dn_unf   = step_dn[WIDTH];
  assign dir_up   = (up_dn == DIR_UP);
  assign at_bound = dir_up ? up_ovf : dn_unf;
  assign tc       = en & at_bound;

  always_comb begin
    next_count = count;
    wrap_event = 1'b0;
    if (load) begin
      next_count = WIDTH'(clamp_load(32'(load_val), MAX_VAL));
    end else if (en) begin
      if (!at_bound) begin
        next_count = dir_up ? step_up[WIDTH-1:0] : step_dn[WIDTH-1:0];
      end else if (SATURATE == MODE_WRAP) begin
        next_count = dir_up ? '0 : MaxCnt;
        wrap_event = 1'b1;
      end
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulus counter with load, enable, wrap/saturate and cascade outputs.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
  parameter int unsigned SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap_pulse,
  output logic             at_zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             tc_comb;

  count_next #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .SATURATE (SATURATE)
  ) u_count_next (
    .count      (count_q),
    .up_dn      (up_dn),
    .en         (en),
    .load       (load),
    .load_val   (load_val),
    .next_count (count_d),
    .tc         (tc_comb),
    .wrap_event (wrap_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count      = count_q;
  assign tc         = tc_comb;
  assign wrap_pulse = wrap_q;
  assign at_zero    = (count_q == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench: wrap, BCD, saturate and cascaded instances against an arithmetic model.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up_dn, load;
  logic [3:0] load_val;

  logic [3:0] cnt_def, cnt_bcd, cnt_sat;
  logic       tc_def, tc_bcd, tc_sat;
  logic       wp_def, wp_bcd, wp_sat;
  logic       z_def, z_bcd, z_sat;

  logic       en_c, up_c;
  logic       tie_load = 1'b0;
  logic [3:0] tie_val  = 4'd0;
  logic [3:0] cnt_c0, cnt_c1;
  logic       tc_c0, tc_c1, wp_c0, wp_c1, z_c0, z_c1;

  int n_pass  = 0;
  int n_total = 0;
  int m_def, m_bcd, m_sat, m_dec;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MAX_VAL(15), .SATURATE(0)) u_def (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(cnt_def), .tc(tc_def), .wrap_pulse(wp_def), .at_zero(z_def)
  );
  updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) u_bcd (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(cnt_bcd), .tc(tc_bcd), .wrap_pulse(wp_bcd), .at_zero(z_bcd)
  );
  updown_mod_counter #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(cnt_sat), .tc(tc_sat), .wrap_pulse(wp_sat), .at_zero(z_sat)
  );
  updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) u_c0 (
    .clk(clk), .rst(rst), .en(en_c), .up_dn(up_c), .load(tie_load), .load_val(tie_val),
    .count(cnt_c0), .tc(tc_c0), .wrap_pulse(wp_c0), .at_zero(z_c0)
  );
  updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) u_c1 (
    .clk(clk), .rst(rst), .en(tc_c0), .up_dn(up_c), .load(tie_load), .load_val(tie_val),
    .count(cnt_c1), .tc(tc_c1), .wrap_pulse(wp_c1), .at_zero(z_c1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: the count range is 0..mx, i.e. arithmetic modulo mx+1 or clipped at the ends.
  function automatic int ref_next(int c, bit e, bit ud, bit ld, int lv, int mx, bit sat);
    if (ld) return (lv > mx) ? mx : lv;
    if (!e) return c;
    if (sat) return ud ? ((c < mx) ? c + 1 : mx) : ((c > 0) ? c - 1 : 0);
    return ud ? (c + 1) % (mx + 1) : (c + mx) % (mx + 1);
  endfunction

  function automatic bit ref_bound(int c, bit ud, int mx);
    return ud ? (c == mx) : (c == 0);
  endfunction

  task automatic step(input bit e, input bit ud, input bit ld, input int lv);
    bit w_def, w_bcd;
    en = e; up_dn = ud; load = ld; load_val = lv[3:0];
    #1;
    check("tc_def", tc_def, e && ref_bound(m_def, ud, 15));
    check("tc_bcd", tc_bcd, e && ref_bound(m_bcd, ud, 9));
    check("tc_sat", tc_sat, e && ref_bound(m_sat, ud, 15));
    w_def = !ld && e && ref_bound(m_def, ud, 15);
    w_bcd = !ld && e && ref_bound(m_bcd, ud, 9);
    m_def = ref_next(m_def, e, ud, ld, lv, 15, 1'b0);
    m_bcd = ref_next(m_bcd, e, ud, ld, lv, 9, 1'b0);
    m_sat = ref_next(m_sat, e, ud, ld, lv, 15, 1'b1);
    @(posedge clk);
    #1;
    check("cnt_def", cnt_def, m_def);
    check("cnt_bcd", cnt_bcd, m_bcd);
    check("cnt_sat", cnt_sat, m_sat);
    check("wp_def", wp_def, w_def);
    check("wp_bcd", wp_bcd, w_bcd);
    check("wp_sat", wp_sat, 0);
    check("z_def", z_def, m_def == 0);
    check("z_bcd", z_bcd, m_bcd == 0);
    check("z_sat", z_sat, m_sat == 0);
  endtask

  // Cascade model: a plain decimal value 0..99.
  task automatic cstep(input bit e, input bit ud);
    bit w_hi;
    en_c = e; up_c = ud;
    #1;
    w_hi = e && (ud ? (m_dec == 99) : (m_dec == 0));
    check("tc_c1", tc_c1, w_hi);
    if (e) m_dec = ud ? (m_dec + 1) % 100 : (m_dec + 99) % 100;
    @(posedge clk);
    #1;
    check("cnt_c0", cnt_c0, m_dec % 10);
    check("cnt_c1", cnt_c1, m_dec / 10);
    check("wp_c1", wp_c1, w_hi);
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1;
    check("async_rst_cnt_def", cnt_def, 0);
    check("async_rst_cnt_bcd", cnt_bcd, 0);
    check("async_rst_wp_def", wp_def, 0);
    check("async_rst_wp_bcd", wp_bcd, 0);
    m_def = 0; m_bcd = 0; m_sat = 0; m_dec = 0;
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
    en_c = 1'b0; up_c = 1'b1;
    m_def = 0; m_bcd = 0; m_sat = 0; m_dec = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_cnt_def", cnt_def, 0);
    check("reset_wp_def", wp_def, 0);
    check("reset_cnt_c1", cnt_c1, 0);
    #2 rst = 1'b0;

    // Async reset from count 7, then first enabled edge gives 1.
    step(1'b0, 1'b1, 1'b1, 7);
    check("load7", cnt_def, 7);
    pulse_reset();
    step(1'b1, 1'b1, 1'b0, 0);
    check("first_edge", cnt_def, 1);

    // Down wrap 0 -> 15 with one-cycle pulse.
    step(1'b0, 1'b0, 1'b1, 0);
    step(1'b1, 1'b0, 1'b0, 0);
    check("down_wrap_cnt", cnt_def, 15);
    check("down_wrap_wp", wp_def, 1);
    step(1'b1, 1'b0, 1'b0, 0);
    check("down_wrap_wp_clear", wp_def, 0);

    // BCD: ten up edges from 0 end back at 0; load 12 clamps to 9.
    step(1'b0, 1'b1, 1'b1, 0);
    repeat (10) step(1'b1, 1'b1, 1'b0, 0);
    check("bcd_wrap_cnt", cnt_bcd, 0);
    check("bcd_wrap_wp", wp_bcd, 1);
    step(1'b0, 1'b1, 1'b1, 12);
    check("bcd_load12", cnt_bcd, 9);

    // Saturation at both ends.
    step(1'b0, 1'b1, 1'b1, 14);
    repeat (3) step(1'b1, 1'b1, 1'b0, 0);
    check("sat_top", cnt_sat, 15);
    step(1'b0, 1'b0, 1'b1, 1);
    repeat (2) step(1'b1, 1'b0, 1'b0, 0);
    check("sat_bottom", cnt_sat, 0);

    // Load beats enable, then hold.
    step(1'b0, 1'b1, 1'b1, 8);
    step(1'b1, 1'b1, 1'b1, 5);
    check("load_priority", cnt_def, 5);
    repeat (3) step(1'b0, 1'($urandom % 2), 1'b0, 3);
    check("hold", cnt_def, 5);

    // Pending wrap pulse is cleared by async reset.
    step(1'b0, 1'b1, 1'b1, 15);
    step(1'b1, 1'b1, 1'b0, 0);
    pulse_reset();

    repeat (300) step(1'($urandom % 2), 1'($urandom % 2), ($urandom % 8) == 0,
                      int'($urandom % 16));

    // Two BCD stages: 00..99, 99 -> 00, then reverse at 00 -> 99.
    en = 1'b0; load = 1'b0;
    repeat (99) cstep(1'b1, 1'b1);
    check("casc_99_lo", cnt_c0, 9);
    check("casc_99_hi", cnt_c1, 9);
    cstep(1'b1, 1'b1);
    check("casc_00", cnt_c1, 0);
    check("casc_wp", wp_c1, 1);
    cstep(1'b1, 1'b0);
    check("casc_down_99", cnt_c1, 9);
    repeat (60) cstep(1'($urandom % 2), 1'($urandom % 2));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
